// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants and helpers, used by the timing
// generator and by the sprite mappers for coordinate scaling.
package vga_pkg;

  localparam logic [9:0] H_VISIBLE  = 10'd640;
  localparam logic [9:0] H_FP_END   = 10'd656;
  localparam logic [9:0] H_SYNC_END = 10'd752;
  localparam logic [9:0] H_TOTAL    = 10'd800;
  localparam logic [9:0] V_VISIBLE  = 10'd480;
  localparam logic [9:0] V_FP_END   = 10'd490;
  localparam logic [9:0] V_SYNC_END = 10'd492;
  localparam logic [9:0] V_TOTAL    = 10'd525;

  localparam logic [9:0] H_LAST = H_TOTAL - 10'd1;
  localparam logic [9:0] V_LAST = V_TOTAL - 10'd1;

  // Bit order {blank, vs, hs} is the layout carried through the delay line.
  typedef struct packed {
    logic blank;
    logic vs;
    logic hs;
  } sync_bits_t;

  localparam sync_bits_t DELAY_RESET = '{blank: 1'b0, vs: 1'b1, hs: 1'b1};

  function automatic logic hsync_level(input logic [9:0] hc);
    return !((hc >= H_FP_END) && (hc < H_SYNC_END));
  endfunction

  function automatic logic vsync_level(input logic [9:0] vc);
    return !((vc >= V_FP_END) && (vc < V_SYNC_END));
  endfunction

  function automatic logic is_visible(input logic [9:0] hc, input logic [9:0] vc);
    return (hc < H_VISIBLE) && (vc < V_VISIBLE);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register for the 3-bit {blank, vs, hs} group; every stage
// resets to RESET_VAL so the outputs read as blanked while the line refills.
module sync_delay_line #(
  parameter int         DEPTH     = 2,
  parameter logic [2:0] RESET_VAL = 3'b011
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic [2:0] din,
  output logic [2:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      // Clock and reset are idle when the line is bypassed.
      logic unused_in_bypass;
      assign unused_in_bypass = ^{vga_clk, reset};
      assign dout = din;
    end else begin : g_pipe
      logic [2:0] stage [DEPTH];

      always_ff @(posedge vga_clk) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage[i] <= RESET_VAL;
          end
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
          end
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480 VGA raster timing: pixel/line counters, registered sync/blank/frame
// strobes, and a delayed copy of the syncs aligned to downstream colour regs.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int PIPE_DELAY = 2
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_end,
  output logic       hs_d,
  output logic       vs_d,
  output logic       blank_d
);

  logic [9:0] hc;
  logic [9:0] vc;
  logic [9:0] hc_next;
  logic [9:0] vc_next;
  logic [2:0] sync_now;
  logic [2:0] sync_late;

  always_comb begin
    hc_next = hc + 10'd1;
    vc_next = vc;
    if (hc >= H_LAST) begin
      hc_next = '0;
      vc_next = (vc >= V_LAST) ? 10'd0 : vc + 10'd1;
    end
  end

  // Strobes are decoded from the next counter values so that, once
  // registered, they describe exactly the pixel shown on DrawX/DrawY.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hc        <= '0;
      vc        <= '0;
      hs        <= 1'b1;
      vs        <= 1'b1;
      blank     <= 1'b1;
      frame_end <= 1'b0;
    end else begin
      hc        <= hc_next;
      vc        <= vc_next;
      hs        <= hsync_level(hc_next);
      vs        <= vsync_level(vc_next);
      blank     <= is_visible(hc_next, vc_next);
      frame_end <= (hc_next == H_LAST) && (vc_next == V_LAST);
    end
  end

  assign DrawX = hc;
  assign DrawY = vc;

  assign sync_now = {blank, vs, hs};

  sync_delay_line #(
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL (DELAY_RESET)
  ) u_sync_delay (
    .vga_clk (vga_clk),
    .reset   (reset),
    .din     (sync_now),
    .dout    (sync_late)
  );

  assign {blank_d, vs_d, hs_d} = sync_late;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: hand-computed checkpoints are queued up front and a
// negedge monitor pops and compares them, plus whole-frame tallies.
module tb_vga_timing_gen;

  localparam int FRAME  = 420000;
  localparam int RST_AT = FRAME + 300*800 + 400;

  logic       vga_clk = 1'b0;
  logic       reset   = 1'b1;
  logic [9:0] draw_x, draw_y, draw_x0, draw_y0;
  logic       blank, hs, vs, frame_end, hs_d, vs_d, blank_d;
  logic       blank0, hs0, vs0, frame_end0, hs_d0, vs_d0, blank_d0;

  vga_timing_gen #(.PIPE_DELAY(2)) dut (
    .vga_clk(vga_clk), .reset(reset), .DrawX(draw_x), .DrawY(draw_y),
    .blank(blank), .hs(hs), .vs(vs), .frame_end(frame_end),
    .hs_d(hs_d), .vs_d(vs_d), .blank_d(blank_d)
  );

  vga_timing_gen #(.PIPE_DELAY(0)) dut0 (
    .vga_clk(vga_clk), .reset(reset), .DrawX(draw_x0), .DrawY(draw_y0),
    .blank(blank0), .hs(hs0), .vs(vs0), .frame_end(frame_end0),
    .hs_d(hs_d0), .vs_d(vs_d0), .blank_d(blank_d0)
  );

  always #20 vga_clk = ~vga_clk;

  typedef struct {
    int         cycle;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs, vs, bl, fe, hs_d, vs_d, bl_d;
  } exp_t;

  exp_t sb[$];
  exp_t e_cur;
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  bit   running = 1'b0;

  int ex, ey;
  bit ehs, evs, ebl, efe, dhs, dvs, dbl;
  bit p1_hs = 1'b1, p1_vs = 1'b1, p1_bl = 1'b0;
  bit p2_hs = 1'b1, p2_vs = 1'b1, p2_bl = 1'b0;
  int model_mis = 0, delay_mis = 0, pass_mis = 0, range_bad = 0;
  int blank_cnt = 0, vs_low_cnt = 0, hs_low_cnt = 0, fe_cnt = 0, fe_cyc = -1;

  function automatic void expectAt(input int c, input int x, input int y,
                                   input bit hs_e, input bit vs_e, input bit bl_e,
                                   input bit fe_e, input bit hsd_e, input bit vsd_e,
                                   input bit bld_e);
    exp_t e;
    e.cycle = c;     e.x = 10'(x);     e.y = 10'(y);
    e.hs = hs_e;     e.vs = vs_e;      e.bl = bl_e;   e.fe = fe_e;
    e.hs_d = hsd_e;  e.vs_d = vsd_e;   e.bl_d = bld_e;
    sb.push_back(e);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s @cycle %0d: got %0d, wanted %0d", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit rst_val, input int edges);
    reset = rst_val;
    repeat (edges) @(posedge vga_clk);
    #1;
  endtask

  always @(negedge vga_clk) begin
    if (running) begin
      while (sb.size() > 0 && sb[0].cycle == cyc) begin
        e_cur = sb.pop_front();
        checkOutput("DrawX", 32'(draw_x), 32'(e_cur.x));
        checkOutput("DrawY", 32'(draw_y), 32'(e_cur.y));
        checkOutput("hs", 32'(hs), 32'(e_cur.hs));
        checkOutput("vs", 32'(vs), 32'(e_cur.vs));
        checkOutput("blank", 32'(blank), 32'(e_cur.bl));
        checkOutput("frame_end", 32'(frame_end), 32'(e_cur.fe));
        checkOutput("hs_d", 32'(hs_d), 32'(e_cur.hs_d));
        checkOutput("vs_d", 32'(vs_d), 32'(e_cur.vs_d));
        checkOutput("blank_d", 32'(blank_d), 32'(e_cur.bl_d));
        checkOutput("hs_d_nodelay", 32'(hs_d0), 32'(e_cur.hs));
        checkOutput("vs_d_nodelay", 32'(vs_d0), 32'(e_cur.vs));
        checkOutput("blank_d_nodelay", 32'(blank_d0), 32'(e_cur.bl));
      end

      if (draw_x > 10'd799 || draw_y > 10'd524 || draw_x0 > 10'd799 || draw_y0 > 10'd524)
        range_bad++;

      if (cyc <= RST_AT) begin
        ex  = cyc % 800;
        ey  = (cyc / 800) % 525;
        ehs = !(ex >= 656 && ex <= 751);
        evs = !(ey >= 490 && ey <= 491);
        ebl = (ex < 640) && (ey < 480);
        efe = (ex == 799) && (ey == 524);
        dhs = p2_hs;  dvs = p2_vs;  dbl = p2_bl;
        if (32'(draw_x) != ex || 32'(draw_y) != ey || hs != ehs || vs != evs ||
            blank != ebl || frame_end != efe)
          model_mis++;
        if (32'(draw_x0) != ex || 32'(draw_y0) != ey || hs0 != ehs || vs0 != evs ||
            blank0 != ebl || frame_end0 != efe)
          model_mis++;
        if (hs_d != dhs || vs_d != dvs || blank_d != dbl)
          delay_mis++;
        if (hs_d0 != ehs || vs_d0 != evs || blank_d0 != ebl)
          pass_mis++;
        p2_hs = p1_hs;  p2_vs = p1_vs;  p2_bl = p1_bl;
        p1_hs = ehs;    p1_vs = evs;    p1_bl = ebl;
      end

      if (cyc < FRAME) begin
        if (blank)      blank_cnt++;
        if (!vs)        vs_low_cnt++;
        if (!hs)        hs_low_cnt++;
        if (frame_end) begin
          fe_cnt++;
          fe_cyc = cyc;
        end
      end
      cyc++;
    end
  end

  initial begin
    expectAt(0,        0,   0,   1, 1, 1, 0,  1, 1, 0);
    expectAt(1,        1,   0,   1, 1, 1, 0,  1, 1, 0);
    expectAt(2,        2,   0,   1, 1, 1, 0,  1, 1, 1);
    expectAt(639,      639, 0,   1, 1, 1, 0,  1, 1, 1);
    expectAt(640,      640, 0,   1, 1, 0, 0,  1, 1, 1);
    expectAt(641,      641, 0,   1, 1, 0, 0,  1, 1, 1);
    expectAt(642,      642, 0,   1, 1, 0, 0,  1, 1, 0);
    expectAt(655,      655, 0,   1, 1, 0, 0,  1, 1, 0);
    expectAt(656,      656, 0,   0, 1, 0, 0,  1, 1, 0);
    expectAt(657,      657, 0,   0, 1, 0, 0,  1, 1, 0);
    expectAt(658,      658, 0,   0, 1, 0, 0,  0, 1, 0);
    expectAt(751,      751, 0,   0, 1, 0, 0,  0, 1, 0);
    expectAt(752,      752, 0,   1, 1, 0, 0,  0, 1, 0);
    expectAt(753,      753, 0,   1, 1, 0, 0,  0, 1, 0);
    expectAt(754,      754, 0,   1, 1, 0, 0,  1, 1, 0);
    expectAt(799,      799, 0,   1, 1, 0, 0,  1, 1, 0);
    expectAt(800,      0,   1,   1, 1, 1, 0,  1, 1, 0);
    expectAt(801,      1,   1,   1, 1, 1, 0,  1, 1, 0);
    expectAt(802,      2,   1,   1, 1, 1, 0,  1, 1, 1);
    expectAt(383839,   639, 479, 1, 1, 1, 0,  1, 1, 1);
    expectAt(384000,   0,   480, 1, 1, 0, 0,  1, 1, 0);
    expectAt(391999,   799, 489, 1, 1, 0, 0,  1, 1, 0);
    expectAt(392000,   0,   490, 1, 0, 0, 0,  1, 1, 0);
    expectAt(392001,   1,   490, 1, 0, 0, 0,  1, 1, 0);
    expectAt(392002,   2,   490, 1, 0, 0, 0,  1, 0, 0);
    expectAt(393599,   799, 491, 1, 0, 0, 0,  1, 0, 0);
    expectAt(393600,   0,   492, 1, 1, 0, 0,  1, 0, 0);
    expectAt(393601,   1,   492, 1, 1, 0, 0,  1, 0, 0);
    expectAt(393602,   2,   492, 1, 1, 0, 0,  1, 1, 0);
    expectAt(419999,   799, 524, 1, 1, 0, 1,  1, 1, 0);
    expectAt(420000,   0,   0,   1, 1, 1, 0,  1, 1, 0);
    expectAt(420001,   1,   0,   1, 1, 1, 0,  1, 1, 0);
    expectAt(420002,   2,   0,   1, 1, 1, 0,  1, 1, 1);
    expectAt(RST_AT,   400, 300, 1, 1, 1, 0,  1, 1, 1);
    expectAt(RST_AT+1, 0,   0,   1, 1, 1, 0,  1, 1, 0);
    expectAt(RST_AT+2, 1,   0,   1, 1, 1, 0,  1, 1, 0);
    expectAt(RST_AT+3, 2,   0,   1, 1, 1, 0,  1, 1, 1);

    $display("[TB] reset held for 3 cycles, then free-running");
    applyStimulus(1'b1, 3);
    reset   = 1'b0;
    running = 1'b1;
    applyStimulus(1'b0, RST_AT);
    $display("[TB] one-cycle reset pulse at (400,300)");
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 3);
    @(negedge vga_clk);
    #1;

    checkOutput("scoreboard_leftover", 32'(sb.size()), 32'd0);
    checkOutput("model_mismatch_cycles", 32'(model_mis), 32'd0);
    checkOutput("delay2_mismatch_cycles", 32'(delay_mis), 32'd0);
    checkOutput("delay0_mismatch_cycles", 32'(pass_mis), 32'd0);
    checkOutput("out_of_range_cycles", 32'(range_bad), 32'd0);
    checkOutput("blank_count_frame", 32'(blank_cnt), 32'd307200);
    checkOutput("vs_low_count_frame", 32'(vs_low_cnt), 32'd1600);
    checkOutput("hs_low_count_frame", 32'(hs_low_cnt), 32'd50400);
    checkOutput("frame_end_count", 32'(fe_cnt), 32'd1);
    checkOutput("frame_end_cycle", 32'(fe_cyc), 32'd419999);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter PIPE_DELAY, default 2, number of vga_clk cycles by which hs_d/vs_d/blank_d lag DrawX/DrawY (legal 0..4).
REQ-002 SHALL have port vga_clk  input  1  pixel clock (25 MHz); sole clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising vga_clk.
REQ-004 SHALL have port DrawX  output  10  current pixel column, 0..799.
REQ-005 SHALL have port DrawY  output  10  current pixel row, 0..524.
REQ-006 SHALL have port blank  output  1  1 = visible pixel (DrawX<640 and DrawY<480), 0 = blanking.
REQ-007 SHALL have port hs  output  1  horizontal sync, active low.
REQ-008 SHALL have port vs  output  1  vertical sync, active low.
REQ-009 SHALL have port frame_end  output  1  one-cycle pulse on last pixel of frame.
REQ-010 SHALL have ports hs_d, vs_d, blank_d  output  1 each  hs/vs/blank delayed PIPE_DELAY cycles, aligned to registered colour output of downstream sprite mappers.

Function
REQ-011 SHALL keep registered counters hc (0..799) and vc (0..524); DrawX=hc, DrawY=vc.
REQ-012 hc SHALL increment by 1 each cycle; at 799 SHALL wrap to 0.
REQ-013 vc SHALL increment only in the cycle hc wraps; at vc=524 with hc=799 SHALL wrap to 0.
REQ-014 hs SHALL be 0 exactly for hc in 656..751, else 1; vs SHALL be 0 exactly for vc in 490..491, else 1.
REQ-015 blank SHALL be 1 iff hc<640 and vc<480.
REQ-016 hs, vs, blank, frame_end SHALL be registered and describe the same (hc,vc) shown on DrawX/DrawY in the same cycle (zero relative skew, no combinational path from counters to these outputs).
REQ-017 frame_end SHALL be 1 iff (hc,vc)=(799,524); exactly one cycle per 420000-cycle frame.
REQ-018 hs_d/vs_d/blank_d SHALL be a PIPE_DELAY-deep shift register fed by hs/vs/blank; PIPE_DELAY=0 SHALL pass them through with zero delay.
REQ-019 Arithmetic SHALL be 10-bit unsigned; no counter value outside stated ranges SHALL ever appear.

Reset
REQ-020 While reset=1 at a clock edge: hc=0, vc=0, hs=1, vs=1, blank=1, frame_end=0.
REQ-021 Reset SHALL clear every stage of the delay line to hs_d=1, vs_d=1, blank_d=0 (blanked during refill).
REQ-022 Reset asserted mid-frame SHALL take effect on the next edge regardless of counter position; first cycle after release SHALL show (0,0).

Structure
REQ-023 Timing constants (H_VISIBLE=640, H_FP_END=656, H_SYNC_END=752, H_TOTAL=800, V_VISIBLE=480, V_FP_END=490, V_SYNC_END=492, V_TOTAL=525) SHALL live in shared package vga_pkg, also used by sprite mappers for scaling.
REQ-024 Delay line SHALL be sub-module sync_delay_line (parameter DEPTH, 3-bit data, per-bit reset value).

Verification
REQ-025 Reset 3 cycles, release, run 800 cycles -> DrawX 0..799 then 0, DrawY 0 then 1 on cycle 800; hs low cycles 656..751 only.
REQ-026 Run one full frame from reset -> frame_end high only at cycle 419999, (DrawX,DrawY)=(799,524); vs low only for DrawY 490..491 (1600 cycles).
REQ-027 Count blank=1 over one frame -> exactly 307200; blank=0 at (640,0) and (0,480), 1 at (639,479).
REQ-028 PIPE_DELAY=2: compare hs_d to hs -> hs_d equals hs from 2 cycles earlier; blank_d=0 for first 2 cycles after reset.
REQ-029 Assert reset at (400,300) for 1 cycle -> next cycle (0,0), hs=1, vs=1, frame_end=0, delay line cleared.
REQ-030 PIPE_DELAY=0 build -> hs_d/vs_d/blank_d bitwise equal to hs/vs/blank every cycle for one frame.
